// File: rtl/element_scheduler_pkg.sv
// element_scheduler_pkg
//   Shared definitions for the element scheduler: FSM state encoding,
//   element-unit operation/precision field widths and the default credit
//   depth (maximum issued-but-uncompleted rows).
package element_scheduler_pkg;

    localparam int OP_W                = 4;
    localparam int PREC_W              = 6;
    localparam int MAX_OUTSTANDING_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/element_sched_credit.sv
// element_sched_credit
//   Outstanding-row counter. Counts rows issued to the element unit that
//   have not yet reported completion.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     inc_i         a row was issued this cycle
//     dec_i         the element unit completed a row this cycle
//     count_o       current outstanding count
//     avail_o       a credit is free (count_o < MAX_OUTSTANDING)
//     underflow_o   completion seen while nothing was outstanding (count
//                   holds at zero in that case)
module element_sched_credit
    import element_scheduler_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             avail_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Issue and completion in the same cycle cancel out, including at zero.
    always_comb begin
        count_d     = count_q;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign avail_o = (count_q < CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/element_scheduler.sv
// element_scheduler
//   Walks a job of consecutive psum-buffer rows, issuing one row-read request
//   per cycle to the psum buffer / element unit while credits allow, then
//   waits for all rows to complete and pulses done.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     cfg_valid / cfg_ready    job descriptor handshake (ready only in IDLE)
//     cfg_base_addr            first row; cfg_num_rows row count
//     cfg_op, cfg_in_prec, cfg_out_prec   element-unit settings for the job
//     rd_valid / rd_ready / rd_addr       row-read request
//     eu_operation, eu_input_precision, eu_output_precision  latched settings
//     eu_row_done              one-cycle pulse per completed row
//     busy, done (pulse), err (sticky until next accept)
//     dbg_state                current FSM state
//   Optional feature (macro ELEMENT_SCHED_PERF_CNT_EN): perf_busy_cycles and
//   perf_stall_cycles saturating counters, cleared on reset and job accept.
//
//   Handshake rule: a transfer happens on a rising edge where valid and ready
//   are both 1; valid never depends on ready, and rd_addr is held while
//   rd_valid is 1 and rd_ready is 0.
module element_scheduler
    import element_scheduler_pkg::*;
#(
    parameter int ADDR_W          = 8,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W:0]   cfg_num_rows,
    input  logic [3:0]        cfg_op,
    input  logic [5:0]        cfg_in_prec,
    input  logic [5:0]        cfg_out_prec,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        eu_operation,
    output logic [5:0]        eu_input_precision,
    output logic [5:0]        eu_output_precision,
    input  logic              eu_row_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
`ifdef ELEMENT_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]       perf_busy_cycles,
    output logic [31:0]       perf_stall_cycles
`endif
);

    // Largest legal job: every row of the buffer exactly once.
    localparam logic [ADDR_W:0] ROWS_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [ADDR_W:0]   rows_q, rows_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [PREC_W-1:0] in_prec_q, in_prec_d;
    logic [PREC_W-1:0] out_prec_q, out_prec_d;
    logic              err_q, err_d;

    logic              cfg_accept;
    logic              rd_fire;
    logic              credit_avail;
    logic              credit_underflow;
    logic [CNT_W-1:0]  credit_count;

    element_sched_credit #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (rd_fire),
        .dec_i       (eu_row_done),
        .count_o     (credit_count),
        .avail_o     (credit_avail),
        .underflow_o (credit_underflow)
    );

    assign cfg_accept = cfg_valid && (state_q == ST_IDLE);
    assign rd_fire    = rd_valid && rd_ready;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        issued_d   = issued_q;
        rows_d     = rows_q;
        op_d       = op_q;
        in_prec_d  = in_prec_q;
        out_prec_d = out_prec_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_accept) begin
                    addr_d     = cfg_base_addr;
                    issued_d   = '0;
                    op_d       = cfg_op;
                    in_prec_d  = cfg_in_prec;
                    out_prec_d = cfg_out_prec;
                    if (cfg_num_rows == '0) begin
                        // Empty job: nothing to issue, report completion at once.
                        rows_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        rows_d  = (cfg_num_rows > ROWS_MAX) ? ROWS_MAX : cfg_num_rows;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (rd_fire) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_q + (ADDR_W + 1)'(1);
                    if (issued_d == rows_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (credit_count == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept clears err unless the new descriptor is itself bad; a stray
        // completion sets it regardless.
        if (cfg_accept) begin
            err_d = (cfg_num_rows == '0) || (cfg_num_rows > ROWS_MAX);
        end
        if (credit_underflow) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            issued_q   <= '0;
            rows_q     <= '0;
            op_q       <= '0;
            in_prec_q  <= '0;
            out_prec_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            issued_q   <= issued_d;
            rows_q     <= rows_d;
            op_q       <= op_d;
            in_prec_q  <= in_prec_d;
            out_prec_q <= out_prec_d;
            err_q      <= err_d;
        end
    end

    assign cfg_ready           = (state_q == ST_IDLE);
    assign rd_valid            = (state_q == ST_ISSUE) && credit_avail;
    assign rd_addr             = addr_q;
    assign eu_operation        = op_q;
    assign eu_input_precision  = in_prec_q;
    assign eu_output_precision = out_prec_q;
    assign busy                = (state_q != ST_IDLE);
    assign done                = (state_q == ST_DONE);
    assign err                 = err_q;
    assign dbg_state           = state_q;

`ifdef ELEMENT_SCHED_PERF_CNT_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (cfg_accept) begin
            perf_busy_d  = '0;
            perf_stall_d = '0;
        end else begin
            if (busy && (perf_busy_q != '1)) begin
                perf_busy_d = perf_busy_q + 32'd1;
            end
            if (rd_valid && !rd_ready && (perf_stall_q != '1)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
